// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding the architectural HI/LO
// registers. The result is computed and latched when the operation is issued,
// then held back for a fixed per-class latency so that busy timing matches the
// pipeline's stall model.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset; clears all state
//   start  in   issue strobe for md_op (ignored while busy)
//   md_op  in   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   src0   in   rs: multiplicand / dividend / mthi-mtlo data
//   src1   in   rt: multiplier / divisor
//   busy   out  operation in flight
//   hi     out  architectural HI
//   lo     out  architectural LO
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned PROD_W     = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  // Products: sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits are exact.
  logic [PROD_W-1:0] prod_s, prod_u;
  assign prod_s = {{WIDTH{src0[WIDTH-1]}}, src0} * {{WIDTH{src1[WIDTH-1]}}, src1};
  assign prod_u = {{WIDTH{1'b0}}, src0} * {{WIDTH{1'b0}}, src1};

  // Divisor of 1 replaces the illegal cases: for signed overflow it yields
  // exactly the required q=src0, r=0; divide-by-zero is overridden below.
  logic                    div_zero, div_ovf;
  logic [WIDTH-1:0]        dvsr_s, dvsr_u;
  logic signed [WIDTH-1:0] quot_s, rem_s;
  logic [WIDTH-1:0]        quot_u, rem_u;
  assign div_zero = (src1 == '0);
  assign div_ovf  = (src0 == MOST_NEG) && (src1 == '1);
  assign dvsr_s   = (div_zero || div_ovf) ? WIDTH'(1) : src1;
  assign dvsr_u   = div_zero ? WIDTH'(1) : src1;
  assign quot_s   = $signed(src0) / $signed(dvsr_s);
  assign rem_s    = $signed(src0) % $signed(dvsr_s);
  assign quot_u   = src0 / dvsr_u;
  assign rem_u    = src0 % dvsr_u;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  // Next-state: issue in IDLE, count down in RUN, commit on the last edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT: begin
              pend_hi_d = prod_s[PROD_W-1:WIDTH];
              pend_lo_d = prod_s[WIDTH-1:0];
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = S_RUN;
            end
            OP_MULTU: begin
              pend_hi_d = prod_u[PROD_W-1:WIDTH];
              pend_lo_d = prod_u[WIDTH-1:0];
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = S_RUN;
            end
            OP_DIV: begin
              pend_hi_d = div_zero ? src0 : rem_s;
              pend_lo_d = div_zero ? '1 : quot_s;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = S_RUN;
            end
            OP_DIVU: begin
              pend_hi_d = div_zero ? src0 : rem_u;
              pend_lo_d = div_zero ? '1 : quot_u;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = S_RUN;
            end
            OP_MTHI: hi_d = src0;
            OP_MTLO: lo_d = src0;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed-vector bench for md_unit. One instance uses the default
// latencies (5/10), a second uses 1/1 to check single-cycle busy pulses.
module tb_md_unit;

  localparam int unsigned W = 32;
  localparam logic [2:0] NONE = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                         DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6, RSVD = 3'd7;

  logic         clk = 1'b0;
  logic         reset, start, start_f;
  logic [2:0]   md_op, md_op_f;
  logic [W-1:0] src0, src1;
  logic         busy, busy_f;
  logic [W-1:0] hi, lo, hi_f, lo_f;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .src0(src0), .src1(src1), .busy(busy), .hi(hi), .lo(lo)
  );

  md_unit #(.WIDTH(W), .MULT_CYCLES(1), .DIV_CYCLES(1)) u_fast (
    .clk(clk), .reset(reset), .start(start_f), .md_op(md_op_f),
    .src0(src0), .src1(src1), .busy(busy_f), .hi(hi_f), .lo(lo_f)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op on the main instance, count busy cycles, verify HI/LO hold
  // through RUN and the final result. inject pulses MTHI then DIV while busy.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit inject);
    logic [31:0] old_hi, old_lo;
    int n;
    bit hold;
    old_hi = hi;
    old_lo = lo;
    start = 1'b1; md_op = op; src0 = a; src1 = b;
    tick();
    start = 1'b0; md_op = NONE;
    n = 0;
    hold = 1'b1;
    while (busy && n < 64) begin
      n++;
      if (hi !== old_hi || lo !== old_lo) hold = 1'b0;
      start = 1'b0; md_op = NONE;
      if (inject && n == 1) begin
        start = 1'b1; md_op = MTHI; src0 = 32'hDEADBEEF;
      end else if (inject && n == 2) begin
        start = 1'b1; md_op = DIV; src0 = 32'd100; src1 = 32'd7;
      end
      tick();
    end
    start = 1'b0; md_op = NONE;
    check({tag, " busy cycles"}, 32'(n), 32'(exp_n));
    check({tag, " hold"}, 32'(hold), 32'd1);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    tick();
    check({tag, " idle after"}, 32'(busy), 32'd0);
    check({tag, " hi after"}, hi, exp_hi);
    check({tag, " lo after"}, lo, exp_lo);
  endtask

  initial begin
    bit ok;
    reset = 1'b1; start = 1'b0; start_f = 1'b0;
    md_op = NONE; md_op_f = NONE; src0 = '0; src1 = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state held while idle.
    for (int i = 0; i < 10; i++) begin
      check("reset busy", 32'(busy), 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      tick();
    end
    check("fast reset busy", 32'(busy_f), 32'd0);
    check("fast reset hi", hi_f, 32'd0);
    check("fast reset lo", lo_f, 32'd0);

    // Multiplies.
    run_op("mult -2*3", MULT, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    run_op("multu fffffffe*3", MULTU, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA, 1'b0);
    run_op("mult minneg^2", MULT, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h00000000, 1'b0);
    run_op("multu max^2", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001, 1'b0);

    // Divides, including zero divisor and signed overflow.
    run_op("div -7/2", DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div 7/-2", DIV, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_op("divu 7/0", DIVU, 32'd7, 32'd0, 10, 32'h00000007, 32'hFFFFFFFF, 1'b0);
    run_op("div -5/0", DIV, 32'hFFFFFFFB, 32'd0, 10, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0);
    run_op("div ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 1'b0);
    run_op("divu 80000000/ffffffff", DIVU, 32'h80000000, 32'hFFFFFFFF, 10, 32'h80000000, 32'h00000000, 1'b0);
    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 10, 32'h00000002, 32'h0000000E, 1'b0);

    // MTHI then MTLO on consecutive edges.
    start = 1'b1; md_op = MTHI; src0 = 32'h12345678;
    tick();
    check("mthi busy", 32'(busy), 32'd0);
    check("mthi hi", hi, 32'h12345678);
    check("mthi lo untouched", lo, 32'h0000000E);
    md_op = MTLO; src0 = 32'h9ABCDEF0;
    tick();
    check("mtlo busy", 32'(busy), 32'd0);
    check("mtlo hi", hi, 32'h12345678);
    check("mtlo lo", lo, 32'h9ABCDEF0);

    // Reserved and NONE opcodes do nothing.
    md_op = RSVD; src0 = 32'h11111111; src1 = 32'h22222222;
    tick();
    md_op = NONE;
    tick();
    start = 1'b0;
    check("rsvd busy", 32'(busy), 32'd0);
    check("rsvd hi", hi, 32'h12345678);
    check("rsvd lo", lo, 32'h9ABCDEF0);

    // Starts issued while busy must be ignored.
    run_op("mult with ignored starts", MULT, 32'd6, 32'd7, 5, 32'h00000000, 32'h0000002A, 1'b1);

    // Reset on cycle 3 of a DIV abandons it.
    start = 1'b1; md_op = MTHI; src0 = 32'h00000055;
    tick();
    md_op = DIV; src0 = 32'hFFFFFFF9; src1 = 32'd2;
    tick();
    start = 1'b0; md_op = NONE;
    check("pre-reset busy", 32'(busy), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) ok = 1'b0;
    end
    check("no late write", 32'(ok), 32'd1);

    // Single-cycle latency instance.
    start_f = 1'b1; md_op_f = MULT; src0 = 32'hFFFFFFFE; src1 = 32'd3;
    tick();
    start_f = 1'b0; md_op_f = NONE;
    check("fast mult busy", 32'(busy_f), 32'd1);
    tick();
    check("fast mult done", 32'(busy_f), 32'd0);
    check("fast mult hi", hi_f, 32'hFFFFFFFF);
    check("fast mult lo", lo_f, 32'hFFFFFFFA);

    start_f = 1'b1; md_op_f = DIV; src0 = 32'hFFFFFFF9; src1 = 32'd2;
    tick();
    start_f = 1'b0; md_op_f = NONE;
    check("fast div busy", 32'(busy_f), 32'd1);
    tick();
    check("fast div done", 32'(busy_f), 32'd0);
    check("fast div hi", hi_f, 32'hFFFFFFFF);
    check("fast div lo", lo_f, 32'hFFFFFFFD);

    // Start held across the completion edge: ignored there, accepted next edge.
    start_f = 1'b1; md_op_f = MULT; src0 = 32'd6; src1 = 32'd7;
    tick();
    check("b2b first busy", 32'(busy_f), 32'd1);
    md_op_f = DIVU; src0 = 32'd100; src1 = 32'd7;
    tick();
    check("b2b completion busy", 32'(busy_f), 32'd0);
    check("b2b completion hi", hi_f, 32'h00000000);
    check("b2b completion lo", lo_f, 32'h0000002A);
    tick();
    start_f = 1'b0; md_op_f = NONE;
    check("b2b second busy", 32'(busy_f), 32'd1);
    check("b2b second hold lo", lo_f, 32'h0000002A);
    tick();
    check("b2b second done", 32'(busy_f), 32'd0);
    check("b2b second hi", hi_f, 32'h00000002);
    check("b2b second lo", lo_f, 32'h0000000E);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
